// File: rtl/val2_arbiter_if.sv
// Bundle of the two requester ports, the shared Val2Generator hookup and the result return of val2_arbiter.
// The arbiter connects through the slave modport; the requesters and the generator sit on the master side.
interface val2_arbiter_if;
  // Handshake: reqN is the requester's valid, gntN is the arbiter's ready; a transfer happens in a cycle
  // where both are high, and the requester holds reqN and its operands stable until that cycle.
  // rsp_valid is a one-cycle pulse with no back-pressure; rsp_id/rsp_val_2 hold between pulses.
  logic        req0;
  logic        req1;
  logic [31:0] rm0;
  logic [31:0] rm1;
  logic [11:0] shift_operand0;
  logic [11:0] shift_operand1;
  logic        imm0;
  logic        imm1;
  logic        select0;
  logic        select1;

  logic        gnt0;
  logic        gnt1;

  logic [31:0] gen_rm;
  logic [11:0] gen_shift_operand;
  logic        gen_imm;
  logic        gen_select;
  logic [31:0] gen_val_2;

  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_val_2;
  logic        busy;

  logic [1:0]  dbg_state;
  logic        dbg_rr_ptr;

  modport slave (
    input  req0, req1,
    input  rm0, rm1, shift_operand0, shift_operand1, imm0, imm1, select0, select1,
    output gnt0, gnt1,
    output gen_rm, gen_shift_operand, gen_imm, gen_select,
    input  gen_val_2,
    output rsp_valid, rsp_id, rsp_val_2, busy,
    output dbg_state, dbg_rr_ptr
  );

  modport master (
    output req0, req1,
    output rm0, rm1, shift_operand0, shift_operand1, imm0, imm1, select0, select1,
    input  gnt0, gnt1,
    input  gen_rm, gen_shift_operand, gen_imm, gen_select,
    output gen_val_2,
    input  rsp_valid, rsp_id, rsp_val_2, busy,
    input  dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/val2_arbiter.sv
// Two-requester arbiter sharing one Val2Generator: IDLE -> ISSUE -> RESP, one result every 3 cycles.
// Define VAL2_ARB_FIXED_PRIO_EN to make requester 0 always win contention instead of round-robin.
module val2_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  val2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        rr_ptr;
  logic        win0;
  logic        win1;
  logic        grant_any;

  logic [31:0] op_rm;
  logic [11:0] op_shift;
  logic        op_imm;
  logic        op_select;

  logic        gnt_id;
  logic [31:0] res_val;
  logic        res_id;

  // Grants are combinational in IDLE and suppressed while reset is asserted.
  always_comb begin
    state_nxt = state;
    win0      = 1'b0;
    win1      = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
`ifdef VAL2_ARB_FIXED_PRIO_EN
          win0 = bus.req0;
`else
          win0 = bus.req0 && (!bus.req1 || !rr_ptr);
`endif
          win1 = bus.req1 && !win0;
        end
        if (win0 || win1) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_any = win0 | win1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand registers load only on a grant; the pointer then favours the requester that lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= RR_INIT;
      op_rm     <= '0;
      op_shift  <= '0;
      op_imm    <= 1'b0;
      op_select <= 1'b0;
      gnt_id    <= 1'b0;
      res_val   <= '0;
      res_id    <= 1'b0;
    end else begin
      if (grant_any) begin
        op_rm     <= win1 ? bus.rm1 : bus.rm0;
        op_shift  <= win1 ? bus.shift_operand1 : bus.shift_operand0;
        op_imm    <= win1 ? bus.imm1 : bus.imm0;
        op_select <= win1 ? bus.select1 : bus.select0;
        gnt_id    <= win1;
        rr_ptr    <= win0;
      end
      if (state == ISSUE) begin
        res_val <= bus.gen_val_2;
        res_id  <= gnt_id;
      end
    end
  end

  assign bus.gnt0              = win0;
  assign bus.gnt1              = win1;
  assign bus.gen_rm            = op_rm;
  assign bus.gen_shift_operand = op_shift;
  assign bus.gen_imm           = op_imm;
  assign bus.gen_select        = op_select;
  assign bus.rsp_valid         = (state == RESP) && !rst;
  assign bus.rsp_id            = res_id;
  assign bus.rsp_val_2         = res_val;
  assign bus.busy              = (state != IDLE) && !rst;
  assign bus.dbg_state         = state;
  assign bus.dbg_rr_ptr        = rr_ptr;

endmodule
